// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse transmitter.
package morse_pkg;

  localparam int unsigned CH_W  = 7;
  localparam int unsigned LEN_W = 3;
  localparam int unsigned PAT_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MARK  = 3'd1,
    ST_SPACE = 3'd2,
    ST_CGAP  = 3'd3,
    ST_WGAP  = 3'd4
  } state_e;

  // Element lengths in Morse units
  localparam logic [LEN_W-1:0] LEN_DOT  = 3'd1;
  localparam logic [LEN_W-1:0] LEN_DASH = 3'd3;
  localparam logic [LEN_W-1:0] LEN_IGAP = 3'd1;
  localparam logic [LEN_W-1:0] LEN_CGAP = 3'd3;
  localparam logic [LEN_W-1:0] LEN_WGAP = 3'd7;

  // Code entry: symbol i is pattern[PAT_W-1-i], 1 = dash
  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic [PAT_W-1:0] pattern;
    logic             valid;
    logic             is_space;
  } code_t;

  function automatic code_t mk_code(input logic [LEN_W-1:0] len, input logic [PAT_W-1:0] pat);
    code_t c;
    c.len      = len;
    c.pattern  = pat;
    c.valid    = 1'b1;
    c.is_space = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/morse_lut.sv
// Combinational ASCII to Morse code-entry lookup.
module morse_lut
  import morse_pkg::*;
(
  input  logic [CH_W-1:0] ch_i,
  output code_t           code_c
);

  logic [CH_W-1:0] up;

  // Fold lowercase to uppercase, then table lookup
  always_comb begin
    up     = ch_i;
    code_c = '0;
    if (ch_i >= 7'h61 && ch_i <= 7'h7A) up = ch_i - 7'h20;
    case (up)
      7'h20: code_c.is_space = 1'b1;
      7'h30: code_c = mk_code(3'd5, 5'b11111);
      7'h31: code_c = mk_code(3'd5, 5'b01111);
      7'h32: code_c = mk_code(3'd5, 5'b00111);
      7'h33: code_c = mk_code(3'd5, 5'b00011);
      7'h34: code_c = mk_code(3'd5, 5'b00001);
      7'h35: code_c = mk_code(3'd5, 5'b00000);
      7'h36: code_c = mk_code(3'd5, 5'b10000);
      7'h37: code_c = mk_code(3'd5, 5'b11000);
      7'h38: code_c = mk_code(3'd5, 5'b11100);
      7'h39: code_c = mk_code(3'd5, 5'b11110);
      7'h41: code_c = mk_code(3'd2, 5'b01000);
      7'h42: code_c = mk_code(3'd4, 5'b10000);
      7'h43: code_c = mk_code(3'd4, 5'b10100);
      7'h44: code_c = mk_code(3'd3, 5'b10000);
      7'h45: code_c = mk_code(3'd1, 5'b00000);
      7'h46: code_c = mk_code(3'd4, 5'b00100);
      7'h47: code_c = mk_code(3'd3, 5'b11000);
      7'h48: code_c = mk_code(3'd4, 5'b00000);
      7'h49: code_c = mk_code(3'd2, 5'b00000);
      7'h4A: code_c = mk_code(3'd4, 5'b01110);
      7'h4B: code_c = mk_code(3'd3, 5'b10100);
      7'h4C: code_c = mk_code(3'd4, 5'b01000);
      7'h4D: code_c = mk_code(3'd2, 5'b11000);
      7'h4E: code_c = mk_code(3'd2, 5'b10000);
      7'h4F: code_c = mk_code(3'd3, 5'b11100);
      7'h50: code_c = mk_code(3'd4, 5'b01100);
      7'h51: code_c = mk_code(3'd4, 5'b11010);
      7'h52: code_c = mk_code(3'd3, 5'b01000);
      7'h53: code_c = mk_code(3'd3, 5'b00000);
      7'h54: code_c = mk_code(3'd1, 5'b10000);
      7'h55: code_c = mk_code(3'd3, 5'b00100);
      7'h56: code_c = mk_code(3'd4, 5'b00010);
      7'h57: code_c = mk_code(3'd3, 5'b01100);
      7'h58: code_c = mk_code(3'd4, 5'b10010);
      7'h59: code_c = mk_code(3'd4, 5'b10110);
      7'h5A: code_c = mk_code(3'd4, 5'b11000);
      default: code_c = '0;
    endcase
  end

endmodule

// File: rtl/morse_tx.sv
// Morse keyer: accepts one byte per ready/ack handshake and keys it on morse_out.
module morse_tx
  import morse_pkg::*;
#(
  parameter int unsigned N           = 8,
  parameter int unsigned UNIT_CYCLES = 10_000_000
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         ready,
  input  logic [N-1:0] d_in,
  output logic         ack,
  output logic         morse_out,
  output logic         busy
);

  localparam int unsigned TW = (UNIT_CYCLES > 2) ? $clog2(UNIT_CYCLES) : 1;

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [LEN_W-1:0] units_q, units_d;
  logic [LEN_W-1:0] sym_q, sym_d;
  logic [CH_W-1:0]  data_q, data_d;
  logic             ack_q, ack_d;
  logic             morse_out_q, morse_out_d;
  logic             busy_q, busy_d;

  logic             accept;
  code_t            code_c;
  logic [LEN_W-1:0] elem_len;
  logic [LEN_W-1:0] bit_idx;
  logic             tick;
  logic             elem_done;
  logic             last_sym;

  if (N > CH_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^d_in[N-1:CH_W];
  end

  // Decode the byte being latched (d_in on acceptance, held byte otherwise)
  morse_lut u_lut (
    .ch_i   (data_d),
    .code_c (code_c)
  );

  // Handshake: latch byte on acceptance; ack held until ready is seen low
  always_comb begin
    accept = (state_q == ST_IDLE) && ready && !ack_q;
    data_d = data_q;
    ack_d  = ack_q;
    if (accept) data_d = d_in[CH_W-1:0];
    if (ack_q)       ack_d = ready;
    else if (accept) ack_d = 1'b1;
  end

  // Next-state, unit timer and symbol sequencing
  always_comb begin
    state_d     = state_q;
    sym_d       = sym_q;
    timer_d     = timer_q;
    units_d     = units_q;
    elem_len    = LEN_DOT;
    bit_idx     = 3'd4 - sym_q;
    tick        = (timer_q == TW'(UNIT_CYCLES - 1));
    last_sym    = (sym_q == code_c.len - 3'd1);
    case (state_q)
      ST_MARK:  elem_len = code_c.pattern[bit_idx] ? LEN_DASH : LEN_DOT;
      ST_SPACE: elem_len = LEN_IGAP;
      ST_CGAP:  elem_len = LEN_CGAP;
      ST_WGAP:  elem_len = LEN_WGAP;
      default:  elem_len = LEN_DOT;
    endcase
    elem_done = tick && (units_q == elem_len - 3'd1);

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (code_c.valid) begin
            state_d = ST_MARK;
            sym_d   = '0;
          end else if (code_c.is_space) begin
            state_d = ST_WGAP;
          end
        end
      end
      ST_MARK:  if (elem_done) state_d = last_sym ? ST_CGAP : ST_SPACE;
      ST_SPACE: begin
        if (elem_done) begin
          state_d = ST_MARK;
          sym_d   = sym_q + 3'd1;
        end
      end
      ST_CGAP:  if (elem_done) state_d = ST_IDLE;
      ST_WGAP:  if (elem_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
      units_d = '0;
    end else if (state_q != ST_IDLE) begin
      timer_d = tick ? '0 : timer_q + TW'(1);
      units_d = tick ? units_q + 3'd1 : units_q;
    end

    morse_out_d = (state_d == ST_MARK);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      units_q     <= '0;
      sym_q       <= '0;
      data_q      <= '0;
      ack_q       <= 1'b0;
      morse_out_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      units_q     <= units_d;
      sym_q       <= sym_d;
      data_q      <= data_d;
      ack_q       <= ack_d;
      morse_out_q <= morse_out_d;
      busy_q      <= busy_d;
    end
  end

  assign ack       = ack_q;
  assign morse_out = morse_out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_morse_tx.sv
// Directed testbench for morse_tx with UNIT_CYCLES = 4.
module tb_morse_tx;

  logic       clk;
  logic       rst_l;
  logic       ready;
  logic [7:0] d_in;
  logic       ack;
  logic       morse_out;
  logic       busy;

  int tests;
  int fails;

  // Run-length capture of morse_out while busy
  int   cap_n;
  int   cap_len [256];
  logic cap_lvl [256];
  int   cap_busy;
  logic cap_ack1;
  logic cap_timeout;

  morse_tx #(.N(8), .UNIT_CYCLES(4)) dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .ready     (ready),
    .d_in      (d_in),
    .ack       (ack),
    .morse_out (morse_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a byte for one accepting edge, then drop ready
  task automatic send(input logic [7:0] b);
    d_in  = b;
    ready = 1'b1;
    step();
    ready = 1'b0;
  endtask

  // Record morse_out runs starting at the current sample until busy drops
  task automatic capture();
    int cyc;
    cyc = 0; cap_n = 0; cap_busy = 0; cap_ack1 = 1'bx;
    while (busy === 1'b1 && cyc < 200) begin
      if (cap_n == 0 || cap_lvl[cap_n-1] !== morse_out) begin
        cap_lvl[cap_n] = morse_out;
        cap_len[cap_n] = 1;
        cap_n++;
      end else begin
        cap_len[cap_n-1]++;
      end
      cap_busy++;
      step();
      cyc++;
      if (cyc == 1) cap_ack1 = ack;
    end
    cap_timeout = (busy === 1'b1);
  endtask

  task automatic test_reset();
    rst_l = 1'b0; ready = 1'b0; d_in = 8'h00;
    repeat (3) step();
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL reset_ack got=%b exp=0", ack); end
    tests++; if (morse_out !== 1'b0) begin fails++; $display("FAIL reset_morse got=%b exp=0", morse_out); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_l = 1'b1;
    step();
  endtask

  task automatic test_letter_e();
    d_in = 8'h45; ready = 1'b1;
    step();
    tests++; if (ack !== 1'b1) begin fails++; $display("FAIL e_ack_set got=%b exp=1", ack); end
    tests++; if (morse_out !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL e_accept got morse=%b busy=%b exp 1/1", morse_out, busy); end
    ready = 1'b0;
    capture();
    tests++; if (cap_ack1 !== 1'b0) begin fails++; $display("FAIL e_ack_clear got=%b exp=0", cap_ack1); end
    tests++; if (cap_timeout !== 1'b0) begin fails++; $display("FAIL e_timeout busy never dropped"); end
    tests++; if (cap_n !== 2) begin fails++; $display("FAIL e_runs got=%0d exp=2", cap_n); end
    tests++; if (cap_lvl[0] !== 1'b1 || cap_len[0] !== 4) begin fails++; $display("FAIL e_mark got lvl=%b len=%0d exp 1/4", cap_lvl[0], cap_len[0]); end
    tests++; if (cap_lvl[1] !== 1'b0 || cap_len[1] !== 12) begin fails++; $display("FAIL e_gap got lvl=%b len=%0d exp 0/12", cap_lvl[1], cap_len[1]); end
    tests++; if (cap_busy !== 16) begin fails++; $display("FAIL e_busy got=%0d exp=16", cap_busy); end
  endtask

  task automatic test_back_to_back();
    int exp_len [4] = '{4, 4, 12, 12};
    logic [7:0] chars [2] = '{8'h41, 8'h61};
    for (int c = 0; c < 2; c++) begin
      send(chars[c]);
      tests++; if (morse_out !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL b2b_accept%0d got morse=%b busy=%b exp 1/1", c, morse_out, busy); end
      capture();
      tests++; if (cap_n !== 4 || cap_timeout !== 1'b0) begin fails++; $display("FAIL b2b_runs%0d got=%0d timeout=%b exp=4", c, cap_n, cap_timeout); end
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (cap_len[i] !== exp_len[i] || cap_lvl[i] !== (i % 2 == 0)) begin
          fails++; $display("FAIL b2b_run%0d_%0d got lvl=%b len=%0d exp len=%0d", c, i, cap_lvl[i], cap_len[i], exp_len[i]);
        end
      end
      tests++; if (cap_busy !== 32) begin fails++; $display("FAIL b2b_busy%0d got=%0d exp=32", c, cap_busy); end
    end
  endtask

  task automatic test_digit_zero();
    int exp_len [10] = '{12, 4, 12, 4, 12, 4, 12, 4, 12, 12};
    send(8'h30);
    capture();
    tests++; if (cap_n !== 10 || cap_timeout !== 1'b0) begin fails++; $display("FAIL zero_runs got=%0d timeout=%b exp=10", cap_n, cap_timeout); end
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (cap_len[i] !== exp_len[i] || cap_lvl[i] !== (i % 2 == 0)) begin
        fails++; $display("FAIL zero_run%0d got lvl=%b len=%0d exp len=%0d", i, cap_lvl[i], cap_len[i], exp_len[i]);
      end
    end
    tests++; if (cap_busy !== 88) begin fails++; $display("FAIL zero_busy got=%0d exp=88", cap_busy); end
  endtask

  task automatic test_space_invalid();
    send(8'h20);
    tests++; if (busy !== 1'b1 || morse_out !== 1'b0) begin fails++; $display("FAIL space_accept got busy=%b morse=%b exp 1/0", busy, morse_out); end
    capture();
    tests++; if (cap_busy !== 28 || cap_timeout !== 1'b0) begin fails++; $display("FAIL space_busy got=%0d exp=28", cap_busy); end
    tests++; if (cap_n !== 1 || cap_lvl[0] !== 1'b0) begin fails++; $display("FAIL space_dark got runs=%0d lvl0=%b exp 1/0", cap_n, cap_lvl[0]); end
    d_in = 8'h23; ready = 1'b1;
    step();
    tests++; if (ack !== 1'b1) begin fails++; $display("FAIL inv_ack got=%b exp=1", ack); end
    tests++; if (busy !== 1'b0 || morse_out !== 1'b0) begin fails++; $display("FAIL inv_quiet got busy=%b morse=%b exp 0/0", busy, morse_out); end
    ready = 1'b0;
    step();
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL inv_ack_clear got=%b exp=0", ack); end
    tests++; if (busy !== 1'b0 || morse_out !== 1'b0) begin fails++; $display("FAIL inv_after got busy=%b morse=%b exp 0/0", busy, morse_out); end
  endtask

  task automatic test_ready_held();
    int highs, busys, rises, ack_lows;
    logic prev;
    highs = 0; busys = 0; rises = 0; ack_lows = 0; prev = 1'b0;
    d_in = 8'h54; ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (morse_out === 1'b1) highs++;
      if (busy === 1'b1) busys++;
      if (morse_out === 1'b1 && prev !== 1'b1) rises++;
      if (ack !== 1'b1) ack_lows++;
      prev = morse_out;
    end
    tests++; if (highs !== 12) begin fails++; $display("FAIL held_high got=%0d exp=12", highs); end
    tests++; if (busys !== 24) begin fails++; $display("FAIL held_busy got=%0d exp=24", busys); end
    tests++; if (rises !== 1) begin fails++; $display("FAIL held_marks got=%0d exp=1", rises); end
    tests++; if (ack_lows !== 0) begin fails++; $display("FAIL held_ack_low got=%0d exp=0", ack_lows); end
    ready = 1'b0;
    step();
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL held_ack_clear got=%b exp=0", ack); end
    step();
    tests++; if (busy !== 1'b0 || morse_out !== 1'b0) begin fails++; $display("FAIL held_reaccept got busy=%b morse=%b exp 0/0", busy, morse_out); end
  endtask

  task automatic test_reset_mid();
    d_in = 8'h41; ready = 1'b1;
    repeat (10) step();
    tests++; if (morse_out !== 1'b1 || ack !== 1'b1) begin fails++; $display("FAIL mid_in_dash got morse=%b ack=%b exp 1/1", morse_out, ack); end
    rst_l = 1'b0; ready = 1'b0;
    step();
    rst_l = 1'b1;
    tests++; if (morse_out !== 1'b0) begin fails++; $display("FAIL mid_morse got=%b exp=0", morse_out); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy got=%b exp=0", busy); end
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL mid_ack got=%b exp=0", ack); end
    step();
    send(8'h45);
    tests++; if (ack !== 1'b1 || morse_out !== 1'b1) begin fails++; $display("FAIL mid_reaccept got ack=%b morse=%b exp 1/1", ack, morse_out); end
    capture();
    tests++; if (cap_n !== 2 || cap_len[0] !== 4 || cap_len[1] !== 12 || cap_busy !== 16) begin
      fails++; $display("FAIL mid_e got runs=%0d len0=%0d len1=%0d busy=%0d exp 2/4/12/16", cap_n, cap_len[0], cap_len[1], cap_busy);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_l = 1'b0; ready = 1'b0; d_in = 8'h00;
    test_reset();
    test_letter_e();
    test_back_to_back();
    repeat (2) step();
    test_digit_zero();
    repeat (2) step();
    test_space_invalid();
    test_ready_held();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
